// File: rtl/freq_meter_ctrl_if.sv
// Control/status bundle between a frequency-meter sequencer and its surroundings.
//   start/cont/abort : measurement requests from the host side
//   ovf_in           : carry out of the last BCD decade
//   cnt_en/cnt_clr   : gate and clear for the decade counter chain
//   latch_en/done    : result-register strobe and completion pulse
//   busy/ovf         : activity flag and overflow of the last measurement
interface freq_meter_ctrl_if;
  logic start;
  logic cont;
  logic abort;
  logic ovf_in;
  logic cnt_en;
  logic cnt_clr;
  logic latch_en;
  logic done;
  logic busy;
  logic ovf;

  modport master (
    output start, cont, abort, ovf_in,
    input  cnt_en, cnt_clr, latch_en, done, busy, ovf
  );

  modport slave (
    input  start, cont, abort, ovf_in,
    output cnt_en, cnt_clr, latch_en, done, busy, ovf
  );
endinterface

// File: rtl/freq_meter_ctrl.sv
// Gate-time sequencer for a BCD frequency counter.
// Each measurement runs CLEAR -> GATE -> SETTLE -> LATCH, timed by one shared
// down-counter; continuous mode rearms straight into CLEAR after LATCH.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : freq_meter_ctrl_if.slave (requests in, counter controls/status out)
module freq_meter_ctrl #(
  parameter int unsigned GATE_CYCLES   = 50000000,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  freq_meter_ctrl_if.slave  bus
);

  localparam int unsigned MAX_A  = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
  localparam int unsigned MAX_P  = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int unsigned TW     = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          sticky, sticky_nxt;

  // Timer holds the remaining cycles minus one; a state ends when it reads 0.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = (timer != '0) ? timer - TW'(1) : '0;
    sticky_nxt = sticky;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
          timer_nxt = CLR_LOAD;
        end
      end
      CLEAR: begin
        sticky_nxt = 1'b0;
        if (timer == '0) begin
          state_nxt = GATE;
          timer_nxt = GATE_LOAD;
        end
      end
      GATE: begin
        if (bus.ovf_in) sticky_nxt = 1'b1;
        if (timer == '0) begin
          state_nxt = SETTLE;
          timer_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (bus.ovf_in) sticky_nxt = 1'b1;
        if (timer == '0) begin
          state_nxt = LATCH;
          timer_nxt = '0;
        end
      end
      LATCH: begin
        if (bus.cont) begin
          state_nxt = CLEAR;
          timer_nxt = CLR_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    if (bus.abort) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end
  end

  // Outputs are registered decodes of the next state, so they line up with
  // the state register without any input-to-output combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      sticky       <= 1'b0;
      bus.cnt_en   <= 1'b0;
      bus.cnt_clr  <= 1'b0;
      bus.latch_en <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.ovf      <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      sticky       <= sticky_nxt;
      bus.cnt_en   <= (state_nxt == GATE);
      bus.cnt_clr  <= (state_nxt == CLEAR);
      bus.latch_en <= (state_nxt == LATCH);
      bus.done     <= (state_nxt == LATCH);
      bus.busy     <= (state_nxt != IDLE);
      if (state_nxt == LATCH) bus.ovf <= sticky_nxt;
    end
  end

endmodule
